// File: rtl/alu.sv
// 16-bit arithmetic/logic/shift unit.
// One-cycle registered result with {CF,ZF,NF,VF,PF,AF} status.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [4:0]  F,
  input  logic        Cin,
  output logic [15:0] Result,
  output logic [5:0]  Status
);

  localparam logic [4:0] OP_TRA = 5'b00000;
  localparam logic [4:0] OP_INC = 5'b00001;
  localparam logic [4:0] OP_DEC = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_ADC = 5'b00101;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SBB = 5'b00111;
  localparam logic [4:0] OP_AND = 5'b01000;
  localparam logic [4:0] OP_OR  = 5'b01001;
  localparam logic [4:0] OP_XOR = 5'b01010;
  localparam logic [4:0] OP_NOT = 5'b01011;
  localparam logic [4:0] OP_SHL = 5'b10000;
  localparam logic [4:0] OP_SHR = 5'b10001;
  localparam logic [4:0] OP_SAL = 5'b10010;
  localparam logic [4:0] OP_SAR = 5'b10011;
  localparam logic [4:0] OP_ROL = 5'b10100;
  localparam logic [4:0] OP_ROR = 5'b10101;
  localparam logic [4:0] OP_RCL = 5'b10110;
  localparam logic [4:0] OP_RCR = 5'b10111;

  logic        step_op;
  logic        carry_op;
  logic [15:0] op2;
  logic        cx;
  logic [16:0] add_w;
  logic [16:0] sub_w;
  logic        add_af;
  logic        sub_af;
  logic        add_vf;
  logic        sub_vf;

  logic [15:0] res;
  logic        cf;
  logic        zf;
  logic        nf;
  logic        vf;
  logic        pf;
  logic        af;

  // INC/DEC use a constant 1 and ignore Cin; only ADC/SBB chain Cin
  always_comb begin
    step_op  = (F == OP_INC) || (F == OP_DEC);
    carry_op = (F == OP_ADC) || (F == OP_SBB);
    op2      = step_op ? 16'h0001 : B;
    cx       = carry_op ? Cin : 1'b0;
  end

  // Shared adder and subtractor; bit 16 is carry-out or borrow
  always_comb begin
    add_w  = {1'b0, A} + {1'b0, op2} + {16'b0, cx};
    sub_w  = {1'b0, A} - {1'b0, op2} - {16'b0, cx};
    add_af = A[4] ^ op2[4] ^ add_w[4];
    sub_af = A[4] ^ op2[4] ^ sub_w[4];
    add_vf = (A[15] == op2[15]) && (add_w[15] != A[15]);
    sub_vf = (A[15] != op2[15]) && (sub_w[15] != A[15]);
  end

  // Opcode decode: result plus op-specific CF/VF/AF
  always_comb begin
    res = 16'h0000;
    cf  = 1'b0;
    vf  = 1'b0;
    af  = 1'b0;
    case (F)
      OP_TRA: res = A;
      OP_INC, OP_ADD, OP_ADC: begin
        res = add_w[15:0];
        cf  = add_w[16];
        vf  = add_vf;
        af  = add_af;
      end
      OP_DEC, OP_SUB, OP_SBB: begin
        res = sub_w[15:0];
        cf  = sub_w[16];
        vf  = sub_vf;
        af  = sub_af;
      end
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_NOT: res = ~A;
      OP_SHL, OP_SAL: begin
        res = {A[14:0], 1'b0};
        cf  = A[15];
        vf  = A[14] ^ A[15];
      end
      OP_SHR: begin
        res = {1'b0, A[15:1]};
        cf  = A[0];
      end
      OP_SAR: begin
        res = {A[15], A[15:1]};
        cf  = A[0];
      end
      OP_ROL: begin
        res = {A[14:0], A[15]};
        cf  = A[15];
      end
      OP_ROR: begin
        res = {A[0], A[15:1]};
        cf  = A[0];
      end
      OP_RCL: begin
        res = {A[14:0], Cin};
        cf  = A[15];
      end
      OP_RCR: begin
        res = {Cin, A[15:1]};
        cf  = A[0];
      end
      default: res = 16'h0000;
    endcase
  end

  // Flags derived from the final result for every opcode
  always_comb begin
    zf = (res == 16'h0000);
    nf = res[15];
    pf = ~^res[7:0];
  end

  // Output registers; reset wins over any sampled operation
  always_ff @(posedge clk) begin
    if (rst) begin
      Result <= 16'h0000;
      Status <= 6'b010010;
    end else begin
      Result <= res;
      Status <= {cf, zf, nf, vf, pf, af};
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu.
// Scoreboard queue of {Result,Status} compared one edge after issue.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic [4:0]  F;
  logic        Cin;
  logic [15:0] Result;
  logic [5:0]  Status;

  int tests;
  int fails;

  logic [21:0] sb[$];

  alu dut (
    .clk(clk),
    .rst(rst),
    .A(A),
    .B(B),
    .F(F),
    .Cin(Cin),
    .Result(Result),
    .Status(Status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] model(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [4:0]  f,
    input logic        c
  );
    int ua, ub, uc, sa, sbv, t, s;
    logic [15:0] r;
    logic cf, vf, af;
    ua = a; ub = b; uc = c;
    sa = $signed(a); sbv = $signed(b);
    r = 0; cf = 0; vf = 0; af = 0;
    case (f)
      5'd0: r = a;
      5'd1: begin
        t = ua + 1; r = t[15:0]; cf = t > 65535;
        vf = (sa + 1) > 32767; af = (ua % 16) + 1 > 15;
      end
      5'd3: begin
        t = ua - 1; r = t[15:0]; cf = ua < 1;
        vf = (sa - 1) < -32768; af = (ua % 16) < 1;
      end
      5'd4, 5'd5: begin
        if (f == 5'd4) uc = 0;
        t = ua + ub + uc; r = t[15:0]; cf = t > 65535;
        s = sa + sbv + uc; vf = (s > 32767) || (s < -32768);
        af = (ua % 16) + (ub % 16) + uc > 15;
      end
      5'd6, 5'd7: begin
        if (f == 5'd6) uc = 0;
        t = ua - ub - uc; r = t[15:0]; cf = ua < ub + uc;
        s = sa - sbv - uc; vf = (s > 32767) || (s < -32768);
        af = (ua % 16) < (ub % 16) + uc;
      end
      5'd8:  r = a & b;
      5'd9:  r = a | b;
      5'd10: r = a ^ b;
      5'd11: r = ~a;
      5'd16, 5'd18: begin
        r = a << 1; cf = a[15]; vf = r[15] ^ a[15];
      end
      5'd17: begin r = a >> 1; cf = a[0]; end
      5'd19: begin r = 16'($signed(a) >>> 1); cf = a[0]; end
      5'd20: begin r = (a << 1) | (a >> 15); cf = a[15]; end
      5'd21: begin r = (a >> 1) | (a << 15); cf = a[0]; end
      5'd22: begin r = (a << 1) | {15'd0, c}; cf = a[15]; end
      5'd23: begin r = (a >> 1) | {c, 15'd0}; cf = a[0]; end
      default: r = 0;
    endcase
    return {r, cf, (r == 0), r[15], vf, ~^r[7:0], af};
  endfunction

  task automatic step(
    input logic        r,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [4:0]  f,
    input logic        c,
    input logic [21:0] exp
  );
    rst = r; A = a; B = b; F = f; Cin = c;
    sb.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [21:0] e;
    step(1'b1, 16'hA5A5, 16'h1234, 5'd4, 1'b1, {16'h0000, 6'b010010});
    tests++;
    e = sb.pop_front();
    if ({Result, Status} !== e) begin
      fails++;
      $display("FAIL reset: got %h/%b want %h/%b",
               Result, Status, e[21:6], e[5:0]);
    end
    step(1'b0, 16'h0000, 16'hFFFF, 5'd0, 1'b1, {16'h0000, 6'b010010});
    tests++;
    e = sb.pop_front();
    if ({Result, Status} !== e) begin
      fails++;
      $display("FAIL tra0: got %h/%b want %h/%b",
               Result, Status, e[21:6], e[5:0]);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  f;
    logic        c;
    logic [15:0] r;
    logic [5:0]  s;
  } vec_t;

  task automatic run_vecs(input string name, input vec_t v[]);
    logic [21:0] e;
    foreach (v[i]) begin
      step(1'b0, v[i].a, v[i].b, v[i].f, v[i].c, {v[i].r, v[i].s});
      tests++;
      e = sb.pop_front();
      if ({Result, Status} !== e) begin
        fails++;
        $display("FAIL %s[%0d]: got %h/%b want %h/%b",
                 name, i, Result, Status, e[21:6], e[5:0]);
      end
    end
  endtask

  task automatic test_incdec();
    vec_t v[] = '{
      '{16'hFFFF, 16'h1234, 5'd1, 1'b1, 16'h0000, 6'b110011},
      '{16'h0000, 16'h1234, 5'd3, 1'b1, 16'hFFFF, 6'b101011},
      '{16'h0000, 16'hFFFF, 5'd1, 1'b1, 16'h0001, 6'b000000}
    };
    run_vecs("incdec", v);
  endtask

  task automatic test_arith();
    vec_t v[] = '{
      '{16'hFFFF, 16'hFFFF, 5'd4, 1'b1, 16'hFFFE, 6'b101001},
      '{16'hFFFF, 16'hFFFF, 5'd5, 1'b1, 16'hFFFF, 6'b101011},
      '{16'h7FFF, 16'h0001, 5'd4, 1'b0, 16'h8000, 6'b001111},
      '{16'hFFFF, 16'hFFFF, 5'd6, 1'b1, 16'h0000, 6'b010010},
      '{16'h0000, 16'h0000, 5'd7, 1'b1, 16'hFFFF, 6'b101011}
    };
    run_vecs("arith", v);
  endtask

  task automatic test_logic();
    vec_t v[] = '{
      '{16'hFFFF, 16'hFFFF, 5'd8,  1'b1, 16'hFFFF, 6'b001010},
      '{16'h0000, 16'h0000, 5'd9,  1'b1, 16'h0000, 6'b010010},
      '{16'hFFFF, 16'hFFFF, 5'd10, 1'b1, 16'h0000, 6'b010010},
      '{16'h0000, 16'h1234, 5'd11, 1'b1, 16'hFFFF, 6'b001010},
      '{16'hFFFF, 16'hFFFF, 5'd24, 1'b1, 16'h0000, 6'b010010},
      '{16'hFFFF, 16'hFFFF, 5'd2,  1'b1, 16'h0000, 6'b010010}
    };
    run_vecs("logic", v);
  endtask

  task automatic test_shift();
    vec_t v[] = '{
      '{16'h8001, 16'h0, 5'd16, 1'b0, 16'h0002, 6'b100100},
      '{16'h8001, 16'h0, 5'd18, 1'b0, 16'h0002, 6'b100100},
      '{16'h8001, 16'h0, 5'd17, 1'b0, 16'h4000, 6'b100010},
      '{16'h8001, 16'h0, 5'd19, 1'b0, 16'hC000, 6'b101010},
      '{16'h8001, 16'h0, 5'd20, 1'b0, 16'h0003, 6'b100010},
      '{16'h8001, 16'h0, 5'd21, 1'b0, 16'hC000, 6'b101010},
      '{16'h8001, 16'h0, 5'd22, 1'b0, 16'h0002, 6'b100000},
      '{16'h8001, 16'h0, 5'd23, 1'b0, 16'h4000, 6'b100010},
      '{16'h8001, 16'h0, 5'd22, 1'b1, 16'h0003, 6'b100010},
      '{16'h8001, 16'h0, 5'd23, 1'b1, 16'hC000, 6'b101010}
    };
    run_vecs("shift", v);
  endtask

  task automatic test_reset_priority();
    logic [21:0] e;
    step(1'b1, 16'hFFFF, 16'hFFFF, 5'd4, 1'b1, {16'h0000, 6'b010010});
    tests++;
    e = sb.pop_front();
    if ({Result, Status} !== e) begin
      fails++;
      $display("FAIL rst_prio: got %h/%b want %h/%b",
               Result, Status, e[21:6], e[5:0]);
    end
    step(1'b0, 16'h0001, 16'h0002, 5'd4, 1'b0, model(16'h1, 16'h2, 5'd4, 1'b0));
    tests++;
    e = sb.pop_front();
    if ({Result, Status} !== e) begin
      fails++;
      $display("FAIL rst_release: got %h/%b want %h/%b",
               Result, Status, e[21:6], e[5:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ops[19] = '{5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                            5'd8, 5'd9, 5'd10, 5'd11, 5'd16, 5'd17,
                            5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};
    logic [15:0] a, b;
    logic c;
    logic [21:0] e;
    foreach (ops[k]) begin
      for (int n = 0; n < 5; n++) begin
        a = 16'($urandom);
        b = 16'($urandom);
        c = 1'($urandom_range(0, 1));
        step(1'b0, a, b, ops[k], c, model(a, b, ops[k], c));
        tests++;
        e = sb.pop_front();
        if ({Result, Status} !== e) begin
          fails++;
          $display("FAIL sweep op=%b a=%h b=%h c=%b: got %h/%b want %h/%b",
                   ops[k], a, b, c, Result, Status, e[21:6], e[5:0]);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [21:0] e;
    step(1'b0, 16'h1234, 16'h4321, 5'd4, 1'b0, {16'h5555, 6'b000010});
    A = 16'hFFFF; F = 5'd11;
    #3;
    tests++;
    e = sb.pop_front();
    if ({Result, Status} !== e) begin
      fails++;
      $display("FAIL hold: got %h/%b want %h/%b",
               Result, Status, e[21:6], e[5:0]);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; A = '0; B = '0; F = '0; Cin = 1'b0;
    @(negedge clk);
    test_reset();
    test_incdec();
    test_arith();
    test_logic();
    test_shift();
    test_reset_priority();
    test_hold();
    test_back_to_back();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard: %0d left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
